// File: rtl/bitonic_sort_top.sv
// Fully pipelined bitonic sorting network.
// N = 2**LOG_INPUT_NUM words enter on a flat bus and leave sorted on a flat bus.
// Every compare-exchange stage is registered, giving LAT = S stages of latency.
// A 1-bit valid shift register runs in lockstep with the data pipeline.
module bitonic_sort_top #(
    parameter int LOG_INPUT_NUM = 3,
    parameter int DATAWIDTH     = 32,
    parameter int SIGNED        = 0,
    parameter int ASCENDING     = 1
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              x_valid,
    input  logic [DATAWIDTH*(32'sd1 << LOG_INPUT_NUM)-1:0]    x,
    output logic [DATAWIDTH*(32'sd1 << LOG_INPUT_NUM)-1:0]    y,
    output logic                                              y_valid
);

    localparam int N = 32'sd1 << LOG_INPUT_NUM;
    localparam int W = DATAWIDTH * N;
    localparam int S = (LOG_INPUT_NUM * (LOG_INPUT_NUM + 32'sd1)) / 32'sd2;

    // Magnitude comparison honouring the SIGNED parameter.
    function automatic logic greater(input logic [DATAWIDTH-1:0] a,
                                     input logic [DATAWIDTH-1:0] b);
        if (SIGNED != 32'sd0) begin
            greater = ($signed(a) > $signed(b));
        end else begin
            greater = (a > b);
        end
    endfunction

    // Compare-exchange of one pair; returns {new_hi, new_lo}.
    // With up = 1 the lower-index slot receives the smaller word.
    function automatic logic [2*DATAWIDTH-1:0] cmp_exchange(input logic [DATAWIDTH-1:0] lo,
                                                            input logic [DATAWIDTH-1:0] hi,
                                                            input logic                 up);
        logic swap;
        if (up) begin
            swap = greater(lo, hi);
        end else begin
            swap = greater(hi, lo);
        end
        if (swap) begin
            cmp_exchange = {lo, hi};
        end else begin
            cmp_exchange = {hi, lo};
        end
    endfunction

    // Merge phase (1-based) that owns flat stage index s.
    // Phase p covers stages p*(p-1)/2 .. p*(p+1)/2-1.
    function automatic int phase_of(input int s);
        int p_found;
        p_found = 32'sd1;
        for (int p = 32'sd1; p <= LOG_INPUT_NUM; p++) begin
            if (s >= (p * (p - 32'sd1)) / 32'sd2) begin
                p_found = p;
            end else begin
                p_found = p_found;
            end
        end
        return p_found;
    endfunction

    logic [S-1:0][W-1:0] stage_q_s;
    logic [S-1:0]        valid_r;

    for (genvar s = 0; s < S; s++) begin : g_stage
        // Phase P, step Q within the phase, pair distance J, direction block size K.
        localparam int P = phase_of(s);
        localparam int Q = s - (P * (P - 32'sd1)) / 32'sd2;
        localparam int J = 32'sd1 << (P - 32'sd1 - Q);
        localparam int K = 32'sd1 << P;

        logic [W-1:0] cur_s;
        logic [W-1:0] nxt_s;
        logic [W-1:0] q_r;

        if (s == 0) begin : g_first
            assign cur_s = x;
        end else begin : g_rest
            assign cur_s = stage_q_s[s-1];
        end

        // N/2 disjoint compare-exchanges; the lower index of each pair drives the swap.
        always_comb begin
            nxt_s = cur_s;
            for (int i = 32'sd0; i < N; i++) begin
                if ((i & J) == 32'sd0) begin
                    {nxt_s[DATAWIDTH*(i+J) +: DATAWIDTH], nxt_s[DATAWIDTH*i +: DATAWIDTH]} =
                        cmp_exchange(cur_s[DATAWIDTH*i +: DATAWIDTH],
                                     cur_s[DATAWIDTH*(i+J) +: DATAWIDTH],
                                     (((i & K) == 32'sd0) == (ASCENDING != 32'sd0)));
                end else begin
                    nxt_s = nxt_s;
                end
            end
        end

        // Stage register: updates every cycle, cleared by reset.
        always_ff @(posedge clk) begin
            if (!rst) begin
                q_r <= {W{1'b0}};
            end else begin
                q_r <= nxt_s;
            end
        end

        assign stage_q_s[s] = q_r;
    end

    if (S == 1) begin : g_valid_one
        // Valid flag tracking the single data stage.
        always_ff @(posedge clk) begin
            if (!rst) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= x_valid;
            end
        end
    end else begin : g_valid_many
        // Valid shift register in lockstep with the data stages.
        always_ff @(posedge clk) begin
            if (!rst) begin
                valid_r <= {S{1'b0}};
            end else begin
                valid_r <= {valid_r[S-2:0], x_valid};
            end
        end
    end

    assign y       = stage_q_s[S-1];
    assign y_valid = valid_r[S-1];

endmodule

// File: tb/tb_bitonic_sort_top.sv
// Directed bench for bitonic_sort_top: three instances (unsigned ascending,
// signed ascending, unsigned descending) share one stimulus stream.
module tb_bitonic_sort_top;

    localparam int W = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         x_valid = 1'b0;
    logic [W-1:0] x = {W{1'b0}};
    logic [W-1:0] y_a, y_s, y_d;
    logic         v_a, v_s, v_d;

    int errors = 0;
    int checks = 0;

    bitonic_sort_top dut_a (.clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .y(y_a), .y_valid(v_a));
    bitonic_sort_top #(.SIGNED(1)) dut_s (.clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .y(y_s), .y_valid(v_s));
    bitonic_sort_top #(.ASCENDING(0)) dut_d (.clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .y(y_d), .y_valid(v_d));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bits(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pk(input logic [31:0] e0, input logic [31:0] e1,
                                        input logic [31:0] e2, input logic [31:0] e3,
                                        input logic [31:0] e4, input logic [31:0] e5,
                                        input logic [31:0] e6, input logic [31:0] e7);
        pk = {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    // Reference: unsigned ascending bubble sort of eight words.
    function automatic logic [W-1:0] ref_sort(input logic [W-1:0] v);
        logic [31:0] e [8];
        logic [31:0] t;
        logic [W-1:0] r;
        for (int i = 0; i < 8; i++) e[i] = v[32*i +: 32];
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 7 - i; j++) begin
                if (e[j] > e[j+1]) begin
                    t = e[j]; e[j] = e[j+1]; e[j+1] = t;
                end
            end
        end
        for (int i = 0; i < 8; i++) r[32*i +: 32] = e[i];
        return r;
    endfunction

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = v[32*(7-i) +: 32];
        return r;
    endfunction

    // Issue one vector for one cycle and check the valid timing and all three results.
    task automatic send_and_check(input string tag, input logic [W-1:0] xv,
                                  input logic [W-1:0] ea, input logic [W-1:0] es,
                                  input logic [W-1:0] ed);
        x = xv;
        x_valid = 1'b1;
        tick();
        x = {W{1'b0}};
        x_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 6) begin
                chk_bits({tag, "_valid6"}, {v_a, v_s, v_d}, 3'b111);
                chk_vec({tag, "_unsigned"}, y_a, ea);
                chk_vec({tag, "_signed"}, y_s, es);
                chk_vec({tag, "_desc"}, y_d, ed);
            end else begin
                chk_bits({tag, "_idle"}, {v_a, v_s, v_d}, 3'b000);
            end
            tick();
        end
    endtask

    logic [W-1:0] vecs [10];
    logic [W-1:0] held;

    initial begin
        // Reset
        rst = 1'b0;
        tick();
        tick();
        chk_bits("reset_valid", {v_a, v_s, v_d}, 3'b000);
        chk_vec("reset_y", y_a, {W{1'b0}});
        chk_vec("reset_y_desc", y_d, {W{1'b0}});
        rst = 1'b1;

        // Basic sort
        send_and_check("basic", pk(5, 3, 7, 1, 8, 2, 6, 4),
                       pk(1, 2, 3, 4, 5, 6, 7, 8),
                       pk(1, 2, 3, 4, 5, 6, 7, 8),
                       pk(8, 7, 6, 5, 4, 3, 2, 1));

        // Signedness
        send_and_check("sign", pk(32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h7FFFFFFF, 0, 0, 0, 0),
                       pk(0, 0, 0, 0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF),
                       pk(32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h1, 32'h7FFFFFFF),
                       pk(32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1, 0, 0, 0, 0));

        // Descending order
        send_and_check("ramp", pk(0, 1, 2, 3, 4, 5, 6, 7),
                       pk(0, 1, 2, 3, 4, 5, 6, 7),
                       pk(0, 1, 2, 3, 4, 5, 6, 7),
                       pk(7, 6, 5, 4, 3, 2, 1, 0));

        // Duplicates
        send_and_check("all_a5", {8{32'hA5A5A5A5}}, {8{32'hA5A5A5A5}},
                       {8{32'hA5A5A5A5}}, {8{32'hA5A5A5A5}});
        send_and_check("dup81", pk(8, 8, 1, 1, 8, 1, 8, 1),
                       pk(1, 1, 1, 1, 8, 8, 8, 8),
                       pk(1, 1, 1, 1, 8, 8, 8, 8),
                       pk(8, 8, 8, 8, 1, 1, 1, 1));

        // Back-to-back throughput
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 8; k++) vecs[i][32*k +: 32] = $urandom();
        end
        for (int t = 0; t < 18; t++) begin
            if (t < 10) begin
                x = vecs[t];
                x_valid = 1'b1;
            end else begin
                x = {W{1'b0}};
                x_valid = 1'b0;
            end
            tick();
            if (t >= 5 && t < 15) begin
                chk_bits("b2b_valid", {v_a, 1'b1, v_d}, 3'b111);
                chk_vec("b2b_unsigned", y_a, ref_sort(vecs[t-5]));
                chk_vec("b2b_desc", y_d, rev(ref_sort(vecs[t-5])));
            end else begin
                chk_bits("b2b_idle", {v_a, 1'b0, v_d}, 3'b000);
            end
        end

        // Held x_valid with constant x
        held = pk(9, 0, 32'hDEADBEEF, 4, 4, 32'h10, 2, 32'h7);
        x = held;
        x_valid = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t >= 6) begin
                chk_bits("held_valid", {v_a, v_s, v_d}, 3'b111);
                chk_vec("held_y", y_a, pk(0, 2, 4, 4, 7, 9, 32'h10, 32'hDEADBEEF));
            end else begin
                chk_bits("held_pre", {v_a, v_s, v_d}, 3'b000);
            end
        end
        x = {W{1'b0}};
        x_valid = 1'b0;
        for (int t = 0; t < 8; t++) tick();

        // Reset mid-flight
        x = pk(3, 1, 4, 1, 5, 9, 2, 6);
        x_valid = 1'b1;
        tick();
        x = {W{1'b0}};
        x_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int c = 4; c <= 10; c++) begin
            chk_bits("flush_valid", {v_a, v_s, v_d}, 3'b000);
            chk_vec("flush_y", y_a, {W{1'b0}});
            tick();
        end
        send_and_check("post_reset", pk(3, 1, 4, 1, 5, 9, 2, 6),
                       pk(1, 1, 2, 3, 4, 5, 6, 9),
                       pk(1, 1, 2, 3, 4, 5, 6, 9),
                       pk(9, 6, 5, 4, 3, 2, 1, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
